input_debouncer: RTL and testbench

Front-end conditioner for a raw asynchronous digital input. It synchronises the input, rejects glitches shorter than a programmable stability window, and drives a clean level plus single-cycle edge strobes. Its signal_out feeds the signal_in port of the downstream falling-edge event counter. It also keeps a saturating count of rejected glitches for diagnostics.

---
 rtl/input_debouncer_if.sv | 23 ++
 rtl/input_debouncer.sv | 111 +++++++++++
 tb/tb_input_debouncer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw-input source and the debouncer.
// The source side (master) drives the raw level and controls; the debouncer (slave) returns the clean level.
interface input_debouncer_if #(
  parameter int GLITCH_W = 8
);
  logic                raw_in;
  logic                enable;
  logic                glitch_nul;
  logic                signal_out;
  logic                rise_pulse;
  logic                fall_pulse;
  logic [GLITCH_W-1:0] glitch_count;

  modport master (
    output raw_in, enable, glitch_nul,
    input  signal_out, rise_pulse, fall_pulse, glitch_count
  );

  modport slave (
    input  raw_in, enable, glitch_nul,
    output signal_out, rise_pulse, fall_pulse, glitch_count
  );
endinterface

// File: rtl/input_debouncer.sv
// Synchronises a raw input, rejects pulses shorter than STABLE_CYCLES samples,
// and emits a registered clean level, one-cycle edge strobes and a saturating glitch count.
module input_debouncer #(
  parameter int STABLE_CYCLES = 16,
  parameter int GLITCH_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input_debouncer_if.slave   bus
);
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_param
    $error("input_debouncer: STABLE_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {LOW_STABLE, CHK_HIGH, HIGH_STABLE, CHK_LOW} state_t;

  localparam logic [7:0]          CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GC_MAX   = '1;

  logic                sync_ff1, sync_ff2, sync_in;
  state_t              state, state_nxt;
  logic [7:0]          cnt, cnt_nxt;
  logic                glitch;
  logic                so, so_nxt;
  logic                rp, rp_nxt;
  logic                fp, fp_nxt;
  logic [GLITCH_W-1:0] gc, gc_nxt;

  assign sync_in = sync_ff2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
      state    <= LOW_STABLE;
      cnt      <= '0;
      so       <= 1'b0;
      rp       <= 1'b0;
      fp       <= 1'b0;
      gc       <= '0;
    end else begin
      sync_ff1 <= bus.raw_in;
      sync_ff2 <= sync_ff1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      so       <= so_nxt;
      rp       <= rp_nxt;
      fp       <= fp_nxt;
      gc       <= gc_nxt;
    end
  end

  // With enable low nothing moves, which also keeps both strobes at 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    glitch    = 1'b0;
    if (bus.enable) begin
      unique case (state)
        LOW_STABLE:
          if (sync_in) begin
            state_nxt = CHK_HIGH;
            cnt_nxt   = 8'd1;
          end
        CHK_HIGH:
          if (!sync_in) begin
            state_nxt = LOW_STABLE;
            cnt_nxt   = '0;
            glitch    = 1'b1;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HIGH_STABLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        HIGH_STABLE:
          if (!sync_in) begin
            state_nxt = CHK_LOW;
            cnt_nxt   = 8'd1;
          end
        CHK_LOW:
          if (sync_in) begin
            state_nxt = HIGH_STABLE;
            cnt_nxt   = '0;
            glitch    = 1'b1;
          end else if (cnt == CNT_LAST) begin
            state_nxt = LOW_STABLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
      endcase
    end
  end

  always_comb begin
    rp_nxt = (state == CHK_HIGH) && (state_nxt == HIGH_STABLE);
    fp_nxt = (state == CHK_LOW)  && (state_nxt == LOW_STABLE);
    so_nxt = so;
    if (rp_nxt) so_nxt = 1'b1;
    if (fp_nxt) so_nxt = 1'b0;
    gc_nxt = gc;
    if (!bus.glitch_nul)           gc_nxt = '0;
    else if (glitch && gc != GC_MAX) gc_nxt = gc + GLITCH_W'(1);
  end

  assign bus.signal_out   = so;
  assign bus.rise_pulse   = rp;
  assign bus.fall_pulse   = fp;
  assign bus.glitch_count = gc;
endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboarded bench for input_debouncer: a run-length model predicts each cycle's outputs
// as stimulus is driven; a monitor pops and compares just after every rising edge.
module tb_input_debouncer;
  localparam int SC = 4;
  localparam int GW = 8;
  localparam int GC_MAX = (1 << GW) - 1;

  typedef struct packed {
    logic          so;
    logic          rp;
    logic          fp;
    logic [GW-1:0] gc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  input_debouncer_if #(.GLITCH_W(GW)) bus ();
  input_debouncer #(.STABLE_CYCLES(SC), .GLITCH_W(GW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rise  = 0;
  int   n_fall  = 0;
  exp_t sb[$];

  bit m_s1, m_s2, m_lvl;
  int m_run, m_gc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and push what the outputs must be after its edge.
  task automatic step(input logic r, input logic raw, input logic en, input logic gn);
    exp_t e;
    bit   sin, rp, fp, gl;
    @(negedge clk);
    reset          = r;
    bus.raw_in     = raw;
    bus.enable     = en;
    bus.glitch_nul = gn;
    rp = 0; fp = 0; gl = 0;
    if (!r) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_gc = 0;
    end else begin
      sin  = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      if (en) begin
        if (sin != m_lvl) begin
          m_run++;
          if (m_run == SC) begin
            m_lvl = sin;
            rp    = sin;
            fp    = !sin;
            m_run = 0;
          end
        end else begin
          gl    = (m_run > 0);
          m_run = 0;
        end
      end
      if (!gn)                        m_gc = 0;
      else if (gl && m_gc < GC_MAX)   m_gc++;
    end
    e.so = m_lvl;
    e.rp = rp;
    e.fp = fp;
    e.gc = GW'(m_gc);
    sb.push_back(e);
  endtask

  task automatic run(input int n, input logic raw);
    repeat (n) step(1'b1, raw, 1'b1, 1'b1);
  endtask

  // Wait for the edge belonging to the last step, after the monitor has sampled it.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_signal_out", 32'(bus.signal_out), 32'(e.so));
      chk("sb_rise_pulse", 32'(bus.rise_pulse), 32'(e.rp));
      chk("sb_fall_pulse", 32'(bus.fall_pulse), 32'(e.fp));
      chk("sb_glitch_count", 32'(bus.glitch_count), 32'(e.gc));
      chk("pulse_excl", 32'(bus.rise_pulse & bus.fall_pulse), 32'd0);
      if (bus.rise_pulse === 1'b1) n_rise++;
      if (bus.fall_pulse === 1'b1) n_fall++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0;
    reset = 1'b0; bus.raw_in = 1'b0; bus.enable = 1'b1; bus.glitch_nul = 1'b1;
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_gc = 0;

    // reset with raw high, then release and expect acceptance on the 6th edge
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
    settle();
    chk("rst_signal_out", 32'(bus.signal_out), 32'd0);
    chk("rst_glitch_count", 32'(bus.glitch_count), 32'd0);
    chk("rst_pulses", 32'({bus.rise_pulse, bus.fall_pulse}), 32'd0);
    run(5, 1'b1); settle();
    chk("rise_edge5", 32'(bus.signal_out), 32'd0);
    run(1, 1'b1); settle();
    chk("rise_edge6", 32'(bus.signal_out), 32'd1);
    chk("rise_pulse6", 32'(bus.rise_pulse), 32'd1);
    run(1, 1'b1); settle();
    chk("rise_pulse7", 32'(bus.rise_pulse), 32'd0);

    // clean fall
    run(5, 1'b0); settle();
    chk("fall_edge5", 32'(bus.signal_out), 32'd1);
    run(1, 1'b0); settle();
    chk("fall_edge6", 32'(bus.signal_out), 32'd0);
    chk("fall_pulse6", 32'(bus.fall_pulse), 32'd1);
    chk("fall_gc", 32'(bus.glitch_count), 32'd0);

    // glitch rejection: 2- and 3-cycle pulses rejected, 4-cycle pulse accepted
    run(2, 1'b1); run(6, 1'b0); settle();
    chk("glitch2_gc", 32'(bus.glitch_count), 32'd1);
    run(3, 1'b1); run(6, 1'b0); settle();
    chk("glitch3_gc", 32'(bus.glitch_count), 32'd2);
    chk("glitch3_so", 32'(bus.signal_out), 32'd0);
    r0 = n_rise; f0 = n_fall;
    run(4, 1'b1); run(4, 1'b0); run(4, 1'b1); run(8, 1'b0); settle();
    chk("min_width_rises", 32'(n_rise - r0), 32'd2);
    chk("min_width_falls", 32'(n_fall - f0), 32'd2);
    chk("min_width_gc", 32'(bus.glitch_count), 32'd2);

    // saturation and clear
    repeat (260) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
    end
    run(4, 1'b0); settle();
    chk("sat_gc", 32'(bus.glitch_count), 32'(GC_MAX));
    step(1'b1, 1'b0, 1'b1, 1'b0); settle();
    chk("clr_gc", 32'(bus.glitch_count), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0); settle();
    chk("clr_vs_glitch_gc", 32'(bus.glitch_count), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    run(5, 1'b0); settle();
    chk("post_clr_gc", 32'(bus.glitch_count), 32'd1);

    // enable freeze in CHK_HIGH, resume two edges after re-enable
    r0 = n_rise;
    run(4, 1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b1);
    settle();
    chk("freeze_so", 32'(bus.signal_out), 32'd0);
    chk("freeze_rises", 32'(n_rise - r0), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1); settle();
    chk("resume1_so", 32'(bus.signal_out), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1); settle();
    chk("resume2_so", 32'(bus.signal_out), 32'd1);
    chk("resume2_rise", 32'(bus.rise_pulse), 32'd1);
    run(3, 1'b1); settle();
    chk("resume_rises", 32'(n_rise - r0), 32'd1);

    // reset taken in CHK_LOW and in HIGH_STABLE: level drops without a fall strobe
    f0 = n_fall;
    run(3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1); settle();
    chk("rst_chklow_so", 32'(bus.signal_out), 32'd0);
    chk("rst_chklow_fall", 32'(bus.fall_pulse), 32'd0);
    run(6, 1'b1); settle();
    chk("rst_rerise_so", 32'(bus.signal_out), 32'd1);
    run(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1); settle();
    chk("rst_high_so", 32'(bus.signal_out), 32'd0);
    chk("rst_high_fall", 32'(bus.fall_pulse), 32'd0);
    run(4, 1'b0); settle();
    chk("rst_no_falls", 32'(n_fall - f0), 32'd0);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
